// File: rtl/p_kp_arb_if.sv
// Handshake bundle between N upstream k-path requesters, the arbiter and the
// single downstream decode-control entry.
interface p_kp_arb_if #(
   parameter int N  = 4,
   parameter int CW = 4,
   parameter int SW = (N > 1) ? $clog2(N) : 1
);
   logic [N-1:0]    t_req;
   logic [N*CW-1:0] t_k_ctrl;
   logic [N-1:0]    t_ack;
   logic            i_req;
   logic [CW-1:0]   i_k_ctrl;
   logic            i_ack;
   logic [SW-1:0]   i_src;
   logic            busy;

   // master: the requesters plus the downstream port; slave: the arbiter
   modport master (
      output t_req, t_k_ctrl, i_ack,
      input  t_ack, i_req, i_k_ctrl, i_src, busy
   );
   modport slave (
      input  t_req, t_k_ctrl, i_ack,
      output t_ack, i_req, i_k_ctrl, i_src, busy
   );
endinterface

// File: rtl/p_kp_arb.sv
// Round-robin arbiter sharing one downstream k-path request/ack port among N
// requesters, with grants held for bursts of up to BURST transfers.
module p_kp_arb #(
   parameter int N     = 4,
   parameter int BURST = 4,
   parameter int CW    = 4,
   parameter int SW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic       clk,
   input  logic       reset,
   p_kp_arb_if.slave  bus
);
   typedef enum logic {IDLE, GRANT} st_t;

   st_t           st_reg, st_next;
   logic [SW-1:0] g_reg, g_next;
   logic [SW-1:0] rr_reg, rr_next;
   logic [3:0]    cnt_reg, cnt_next;

   logic [CW-1:0] kc [N];
   logic [N-1:0]  sel;
   logic [N-1:0]  others;
   logic          g_req;
   logic          xfer;
   logic          at_limit;
   logic          rel;

   function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] v);
      if (v == SW'(N - 1))
         return '0;
      return v + 1'b1;
   endfunction

   // First requester at or after start, wrapping; start itself if none.
   function automatic logic [SW-1:0] pick(input logic [N-1:0] req,
                                          input logic [SW-1:0] start);
      logic [SW-1:0] idx;
      logic [SW-1:0] res;
      logic          found;
      idx   = start;
      res   = start;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req[idx]) begin
            res   = idx;
            found = 1'b1;
         end
         idx = wrap_inc(idx);
      end
      return res;
   endfunction

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         assign kc[gi]        = bus.t_k_ctrl[gi*CW +: CW];
         assign sel[gi]       = (st_reg == GRANT) && (g_reg == SW'(gi));
         assign bus.t_ack[gi] = sel[gi] && bus.t_req[gi] && bus.i_ack;
      end
   endgenerate

   assign g_req    = bus.t_req[g_reg];
   assign xfer     = (st_reg == GRANT) && g_req && bus.i_ack;
   assign at_limit = xfer && (cnt_reg == 4'(BURST - 1));
   assign rel      = (st_reg == GRANT) && (at_limit || !g_req);
   assign others   = bus.t_req & ~(N'(1) << g_reg);

   always_comb begin
      bus.i_req    = 1'b0;
      bus.i_k_ctrl = '0;
      bus.i_src    = rr_reg;
      bus.busy     = 1'b0;
      if (st_reg == GRANT) begin
         bus.i_req    = g_req;
         bus.i_k_ctrl = kc[g_reg];
         bus.i_src    = g_reg;
         bus.busy     = 1'b1;
      end
   end

   always_comb begin
      st_next  = st_reg;
      g_next   = g_reg;
      rr_next  = rr_reg;
      cnt_next = cnt_reg;
      case (st_reg)
         IDLE: begin
            if (|bus.t_req) begin
               g_next   = pick(bus.t_req, rr_reg);
               cnt_next = '0;
               st_next  = GRANT;
            end
         end
         GRANT: begin
            if (rel) begin
               rr_next = wrap_inc(g_reg);
               // Handoff without a bubble; the releasing requester is searched last.
               if ((|others) || at_limit) begin
                  g_next   = pick(bus.t_req, wrap_inc(g_reg));
                  cnt_next = '0;
               end else begin
                  st_next = IDLE;
               end
            end else if (xfer) begin
               cnt_next = cnt_reg + 4'd1;
            end
         end
         default: st_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_reg  <= IDLE;
         g_reg   <= '0;
         rr_reg  <= '0;
         cnt_reg <= '0;
      end else begin
         st_reg  <= st_next;
         g_reg   <= g_next;
         rr_reg  <= rr_next;
         cnt_reg <= cnt_next;
      end
   end
endmodule

// File: tb/tb_p_kp_arb.sv
// Directed and random checks of p_kp_arb against a reference model of the
// ownership/burst/round-robin rules.
module tb_p_kp_arb;
   localparam int N     = 4;
   localparam int BURST = 4;
   localparam int CW    = 4;
   localparam int SW    = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   p_kp_arb_if #(.N(N), .CW(CW), .SW(SW)) bus ();
   p_kp_arb #(.N(N), .BURST(BURST), .CW(CW), .SW(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int owner = -1;   // current grant holder in the model, -1 when idle
   int ptr   = 0;    // next search start after a release
   int used  = 0;    // transfers already taken in the current grant
   int wait_x [N];
   bit verbose = 1'b1;
   logic [N-1:0] last_ack;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
      end
   endtask

   function automatic int search(input logic [N-1:0] r, input int from);
      for (int k = 0; k < N; k++)
         if (r[(from + k) % N]) return (from + k) % N;
      return from;
   endfunction

   task automatic compare_model();
      int m_ireq, m_kc, m_ack, m_src, m_busy;
      m_busy = (owner >= 0);
      m_ireq = (owner >= 0) ? int'(bus.t_req[owner]) : 0;
      m_kc   = (owner >= 0) ? int'(bus.t_k_ctrl[owner*CW +: CW]) : 0;
      m_ack  = (m_ireq != 0 && bus.i_ack) ? (1 << owner) : 0;
      m_src  = (owner >= 0) ? owner : ptr;
      chk("m_i_req", int'(bus.i_req), m_ireq);
      chk("m_i_k_ctrl", int'(bus.i_k_ctrl), m_kc);
      chk("m_t_ack", int'(bus.t_ack), m_ack);
      chk("m_i_src", int'(bus.i_src), m_src);
      chk("m_busy", int'(bus.busy), m_busy);
   endtask

   task automatic update_model();
      bit fire, limit;
      logic [N-1:0] oth;
      if (reset) begin
         owner = -1; ptr = 0; used = 0;
      end else if (owner < 0) begin
         if (|bus.t_req) begin
            owner = search(bus.t_req, ptr);
            used  = 0;
         end
      end else begin
         fire  = bus.t_req[owner] && bus.i_ack;
         limit = fire && (used == BURST - 1);
         if (limit || !bus.t_req[owner]) begin
            ptr = (owner + 1) % N;
            oth = bus.t_req;
            oth[owner] = 1'b0;
            if ((|oth) || limit) begin
               owner = search(bus.t_req, ptr);
               used  = 0;
            end else begin
               owner = -1;
            end
         end else if (fire) begin
            used++;
         end
      end
   endtask

   task automatic stress_checks();
      int worst = 0;
      bit xfer;
      xfer = (owner >= 0) && bus.t_req[owner] && bus.i_ack;
      for (int i = 0; i < N; i++) begin
         if (bus.t_req[i] && owner != i) begin
            if (xfer) wait_x[i]++;
         end else begin
            wait_x[i] = 0;
         end
         if (wait_x[i] > worst) worst = wait_x[i];
      end
      chk("ack_onehot", int'($onehot0(bus.t_ack)), 1);
      chk("ack_is_xfer", int'(bus.t_ack != '0), int'(bus.i_req && bus.i_ack));
      chk("fairness", int'(worst <= (N - 1) * BURST), 1);
   endtask

   task automatic cycle(input bit stress);
      @(negedge clk);
      compare_model();
      last_ack = bus.t_ack;
      if (verbose && bus.t_ack != '0)
         $display("ack t_ack=%b i_src=%0d i_k_ctrl=%0d t=%0t",
                  bus.t_ack, bus.i_src, bus.i_k_ctrl, $time);
      if (stress) stress_checks();
      @(posedge clk);
      update_model();
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) wait_x[i] = 0;
      reset = 1'b1;
      bus.t_req = '0;
      bus.t_k_ctrl = '0;
      bus.i_ack = 1'b0;
      @(posedge clk);
      update_model();
      #1;
      cycle(0);
      reset = 1'b0;

      // Idle after reset
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("rst_i_req", int'(bus.i_req), 0);
         chk("rst_t_ack", int'(bus.t_ack), 0);
         chk("rst_busy", int'(bus.busy), 0);
         chk("rst_i_src", int'(bus.i_src), 0);
         cycle(0);
      end

      // Single request from requester 2
      bus.t_k_ctrl = 16'h0900;
      bus.t_req = 4'b0100;
      bus.i_ack = 1'b1;
      #1 chk("t2_idle_i_req", int'(bus.i_req), 0);
      cycle(0);
      #1;
      chk("t2_i_req", int'(bus.i_req), 1);
      chk("t2_k_ctrl", int'(bus.i_k_ctrl), 9);
      chk("t2_t_ack", int'(bus.t_ack), 4);
      chk("t2_i_src", int'(bus.i_src), 2);
      cycle(0);
      bus.t_req = 4'b0000;
      #1;
      chk("t2_rel_i_req", int'(bus.i_req), 0);
      chk("t2_rel_t_ack", int'(bus.t_ack), 0);
      chk("t2_rel_busy", int'(bus.busy), 1);
      cycle(0);
      #1;
      chk("t2_idle_busy", int'(bus.busy), 0);
      chk("t2_idle_src", int'(bus.i_src), 3);

      // All requesting, ack tied high: bursts of 4, rotating without bubbles
      reset = 1'b1;
      cycle(0);
      reset = 1'b0;
      bus.t_k_ctrl = 16'h4321;
      bus.t_req = 4'b1111;
      bus.i_ack = 1'b1;
      cycle(0);
      for (int k = 0; k < 20; k++) begin
         #1;
         chk("t3_t_ack", int'(bus.t_ack), 1 << ((k / 4) % 4));
         chk("t3_k_ctrl", int'(bus.i_k_ctrl), ((k / 4) % 4) + 1);
         cycle(0);
      end

      // Stalled downstream holds grant 1 while requester 3 waits
      reset = 1'b1;
      bus.t_req = '0;
      bus.i_ack = 1'b0;
      cycle(0);
      reset = 1'b0;
      bus.t_k_ctrl = 16'hC050;
      bus.t_req = 4'b0010;
      cycle(0);
      bus.t_req = 4'b1010;
      for (int k = 0; k < 20; k++) begin
         #1;
         chk("t4_i_src", int'(bus.i_src), 1);
         chk("t4_t_ack", int'(bus.t_ack), 0);
         chk("t4_k_ctrl", int'(bus.i_k_ctrl), 5);
         chk("t4_i_req", int'(bus.i_req), 1);
         cycle(0);
      end
      bus.i_ack = 1'b1;
      #1 chk("t4_ack1", int'(bus.t_ack), 2);
      cycle(0);
      bus.t_req = 4'b1000;
      #1;
      chk("t4_bubble_i_req", int'(bus.i_req), 0);
      chk("t4_bubble_src", int'(bus.i_src), 1);
      cycle(0);
      #1;
      chk("t4_next_src", int'(bus.i_src), 3);
      chk("t4_next_ack", int'(bus.t_ack), 8);
      chk("t4_next_k_ctrl", int'(bus.i_k_ctrl), 12);

      // Reset in the middle of a stalled handshake
      bus.i_ack = 1'b0;
      #1 chk("t5_pre_i_req", int'(bus.i_req), 1);
      reset = 1'b1;
      cycle(0);
      reset = 1'b0;
      bus.t_req = 4'b0001;
      #1;
      chk("t5_i_req", int'(bus.i_req), 0);
      chk("t5_busy", int'(bus.busy), 0);
      chk("t5_t_ack", int'(bus.t_ack), 0);
      chk("t5_i_src", int'(bus.i_src), 0);
      cycle(0);
      #1;
      chk("t5_grant_src", int'(bus.i_src), 0);
      chk("t5_grant_req", int'(bus.i_req), 1);
      bus.i_ack = 1'b1;
      #1 chk("t5_ack", int'(bus.t_ack), 1);
      cycle(0);
      bus.t_req = '0;
      cycle(0);
      cycle(0);

      // Random request/ack traffic
      verbose = 1'b0;
      last_ack = '0;
      for (int k = 0; k < 10000; k++) begin
         r = bus.t_req;
         for (int i = 0; i < N; i++) begin
            if (r[i]) begin
               if (last_ack[i] && $urandom_range(1, 0) == 1) r[i] = 1'b0;
            end else if ($urandom_range(2, 0) == 0) begin
               r[i] = 1'b1;
               bus.t_k_ctrl[i*CW +: CW] = 4'($urandom_range(15, 0));
            end
         end
         bus.t_req = r;
         bus.i_ack = ($urandom_range(9, 0) < 7);
         cycle(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
